// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC datapath: Q2.13 angle scale
// and the arctan table used by the rotation stage.
package cordic_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int PI_Q13      = 25736;
    localparam int TWO_PI_Q13  = 51472;
    localparam int HALF_PI_Q13 = 12868;
    localparam int ATAN_N      = 16;

    typedef logic signed [DATA_WIDTH-1:0] q13_t;

    // atan(2^-i) in Q2.13 radians, rounded
    localparam q13_t ATAN_Q13 [ATAN_N] = '{
        16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019,
        16'sd511,  16'sd256,  16'sd128,  16'sd64,
        16'sd32,   16'sd16,   16'sd8,    16'sd4,
        16'sd2,    16'sd1,    16'sd0,    16'sd0
    };

    function automatic q13_t atan_q13(input int unsigned idx);
        atan_q13 = (idx < ATAN_N) ? ATAN_Q13[idx] : '0;
    endfunction

endpackage

// File: rtl/phase_wrap.sv
// Single fold of a widened angle sum back into [-pi, +pi].
// Both operands are already within +/-pi, so one fold suffices.
module phase_wrap #(
    parameter int W  = 18,
    parameter int PI = 25736
) (
    input  logic signed [W-1:0] sum_i,
    output logic signed [W-1:0] wrap_o
);

    localparam logic signed [W-1:0] PI_W     = W'(PI);
    localparam logic signed [W-1:0] TWO_PI_W = W'(2 * PI);

    always_comb begin
        wrap_o = sum_i;
        if (sum_i > PI_W) begin
            wrap_o = sum_i - TWO_PI_W;
        end else if (sum_i < -PI_W) begin
            wrap_o = sum_i + TWO_PI_W;
        end
    end

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase accumulator / sample strobe generator feeding the
// pipelined CORDIC rotation stage (NCO / vector rotator).
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = cordic_pkg::DATA_WIDTH,
    parameter int PI_Q13     = cordic_pkg::PI_Q13,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         sclr_n,
    input  logic                         en,
    input  logic                         load,
    input  logic signed [DATA_WIDTH-1:0] freq_word,
    input  logic signed [DATA_WIDTH-1:0] phase_offset,
    input  logic signed [DATA_WIDTH-1:0] amplitude,
    input  logic        [DIV_WIDTH-1:0]  rate_div,
    output logic                         nd,
    output logic signed [DATA_WIDTH-1:0] x_in,
    output logic signed [DATA_WIDTH-1:0] y_in,
    output logic signed [DATA_WIDTH-1:0] phase_in
);

    localparam int AW = DATA_WIDTH + 2;

    typedef logic signed [DATA_WIDTH-1:0] word_t;
    typedef logic signed [AW-1:0]         wide_t;
    typedef logic        [DIV_WIDTH-1:0]  div_t;

    localparam word_t PI_P = word_t'(PI_Q13);

    function automatic word_t clamp_pi(input word_t v);
        clamp_pi = v;
        if (v > PI_P) begin
            clamp_pi = PI_P;
        end else if (v < -PI_P) begin
            clamp_pi = -PI_P;
        end
    endfunction

    word_t fw_q, fw_d;
    word_t off_q, off_d;
    word_t amp_q, amp_d;
    div_t  div_q, div_d;
    word_t acc_q, acc_d;
    div_t  cnt_q, cnt_d;
    logic  nd_q, nd_d;
    word_t x_q, x_d;
    word_t ph_q, ph_d;

    div_t  div_eff;
    logic  tick;
    wide_t acc_sum, acc_wrap;
    wide_t ph_sum, ph_wrap;

    // A zero divider would strobe every cycle, but the CORDIC
    // samples its inputs for two cycles, so floor it at 1.
    assign div_eff = (div_q == '0) ? div_t'(1) : div_q;
    assign tick    = en && (cnt_q == div_eff);

    assign acc_sum = wide_t'(acc_q) + wide_t'(fw_q);
    assign ph_sum  = wide_t'(acc_q) + wide_t'(off_q);

    phase_wrap #(
        .W  (AW),
        .PI (PI_Q13)
    ) u_wrap_acc (
        .sum_i  (acc_sum),
        .wrap_o (acc_wrap)
    );

    phase_wrap #(
        .W  (AW),
        .PI (PI_Q13)
    ) u_wrap_ph (
        .sum_i  (ph_sum),
        .wrap_o (ph_wrap)
    );

    always_comb begin
        fw_d  = fw_q;
        off_d = off_q;
        amp_d = amp_q;
        div_d = div_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        nd_d  = 1'b0;
        x_d   = x_q;
        ph_d  = ph_q;
        if (load) begin
            fw_d  = clamp_pi(freq_word);
            off_d = clamp_pi(phase_offset);
            amp_d = amplitude;
            div_d = rate_div;
            acc_d = '0;
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
            acc_d = acc_wrap[DATA_WIDTH-1:0];
            ph_d  = ph_wrap[DATA_WIDTH-1:0];
            x_d   = amp_q;
            nd_d  = 1'b1;
        end else if (en) begin
            cnt_d = cnt_q + div_t'(1);
        end
    end

    always_ff @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            fw_q  <= '0;
            off_q <= '0;
            amp_q <= '0;
            div_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            nd_q  <= 1'b0;
            x_q   <= '0;
            ph_q  <= '0;
        end else begin
            fw_q  <= fw_d;
            off_q <= off_d;
            amp_q <= amp_d;
            div_q <= div_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            nd_q  <= nd_d;
            x_q   <= x_d;
            ph_q  <= ph_d;
        end
    end

    assign nd       = nd_q;
    assign x_in     = x_q;
    assign y_in     = '0;
    assign phase_in = ph_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Randomized bench for cordic_phase_gen with a sample-index
// reference model and literal sequence checks.
module tb_cordic_phase_gen;

    localparam int PI = 25736;

    logic              clk = 1'b0;
    logic              sclr_n = 1'b1;
    logic              en = 1'b0;
    logic              load = 1'b0;
    logic signed [15:0] freq_word = '0;
    logic signed [15:0] phase_offset = '0;
    logic signed [15:0] amplitude = '0;
    logic        [15:0] rate_div = '0;
    logic              nd;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic signed [15:0] phase_in;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    cordic_phase_gen dut (
        .clk          (clk),
        .sclr_n       (sclr_n),
        .en           (en),
        .load         (load),
        .freq_word    (freq_word),
        .phase_offset (phase_offset),
        .amplitude    (amplitude),
        .rate_div     (rate_div),
        .nd           (nd),
        .x_in         (x_in),
        .y_in         (y_in),
        .phase_in     (phase_in)
    );

    function automatic int fold(input int s);
        if (s > PI) return s - 2 * PI;
        if (s < -PI) return s + 2 * PI;
        return s;
    endfunction

    function automatic int clampv(input int v);
        if (v > PI) return PI;
        if (v < -PI) return -PI;
        return v;
    endfunction

    function automatic int dmax(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    // accumulator value before sample n: n successive folded steps
    function automatic int acc_after(input int fw, input int n);
        int a = 0;
        for (int i = 0; i < n; i++) a = fold(a + fw);
        return a;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // model: a sample falls on every (div_eff+1)-th enabled cycle
    int m_fw, m_off, m_amp, m_div;
    int e_cnt, n_smp;
    int exp_ph, exp_x;
    bit exp_nd;

    always @(posedge clk or negedge sclr_n) begin
        if (!sclr_n) begin
            m_fw <= 0; m_off <= 0; m_amp <= 0; m_div <= 0;
            e_cnt <= 0; n_smp <= 0;
            exp_ph <= 0; exp_x <= 0; exp_nd <= 1'b0;
        end else begin
            exp_nd <= 1'b0;
            if (load) begin
                m_fw  <= clampv(int'(freq_word));
                m_off <= clampv(int'(phase_offset));
                m_amp <= int'(amplitude);
                m_div <= int'(rate_div);
                e_cnt <= 0;
                n_smp <= 0;
            end else if (en) begin
                e_cnt <= e_cnt + 1;
                if ((e_cnt + 1) % (dmax(m_div) + 1) == 0) begin
                    exp_nd <= 1'b1;
                    exp_ph <= fold(m_off + acc_after(m_fw, n_smp));
                    exp_x  <= m_amp;
                    n_smp  <= n_smp + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("nd", int'(nd), int'(exp_nd));
        chk("phase_in", int'(phase_in), exp_ph);
        chk("x_in", int'(x_in), exp_x);
        chk("y_in", int'(y_in), 0);
    end

    task automatic do_load(input int fw, input int off,
                           input int amp, input int div);
        load = 1'b1;
        freq_word = 16'(fw);
        phase_offset = 16'(off);
        amplitude = 16'(amp);
        rate_div = 16'(div);
        @(negedge clk);
        load = 1'b0;
        freq_word = 16'($urandom);
        phase_offset = 16'($urandom);
        amplitude = 16'($urandom);
        rate_div = 16'($urandom);
    endtask

    task automatic wait_nd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!nd && n < 64);
        if (!nd) chk("nd_timeout", 0, 1);
    endtask

    task automatic run_seq(input string nm, input int fw, input int off,
                           input int amp, input int div, input int exp[$]);
        int n;
        do_load(fw, off, amp, div);
        foreach (exp[i]) begin
            wait_nd(n);
            chk({nm, "_gap"}, n, dmax(div) + 1);
            chk({nm, "_ph"}, int'(phase_in), exp[i]);
            chk({nm, "_x"}, int'(x_in), amp);
        end
    endtask

    initial begin
        int n, cnt_nd;
        #1 sclr_n = 1'b0;
        repeat (3) @(negedge clk);
        sclr_n = 1'b1;
        en = 1'b1;
        repeat (3) begin
            wait_nd(n);
            chk("rst_gap", n, 2);
            chk("rst_ph", int'(phase_in), 0);
        end

        run_seq("basic", 1000, 0, 4096, 3, '{0, 1000, 2000, 3000});
        run_seq("pwrap", 12868, 0, -2000, 1,
                '{0, 12868, 25736, -12868, 0});
        run_seq("nwrap", -20000, -10000, 777, 2,
                '{-10000, 21472, 1472});
        run_seq("fclamp", 30000, 0, 100, 0, '{0, 25736, 0, 25736});
        run_seq("oclamp", 0, -30000, 5, 1, '{-25736, -25736});

        run_seq("ctl", 500, 100, 321, 2, '{100, 600});
        en = 1'b0;
        cnt_nd = 0;
        repeat (5) begin
            @(negedge clk);
            if (nd) cnt_nd++;
        end
        chk("hold_nd_count", cnt_nd, 0);
        chk("hold_ph", int'(phase_in), 600);
        en = 1'b1;
        wait_nd(n);
        chk("resume_gap", n, 3);
        chk("resume_ph", int'(phase_in), 1100);

        // land load on the tick cycle (cnt == div_eff)
        repeat (2) @(negedge clk);
        do_load(700, -300, 55, 2);
        chk("load_tick_nd", int'(nd), 0);
        wait_nd(n);
        chk("reload_gap", n, 3);
        chk("reload_ph0", int'(phase_in), -300);
        wait_nd(n);
        chk("reload_ph1", int'(phase_in), 400);

        repeat (15) begin
            do_load(int'(16'($urandom)) - 32768 + int'(16'($urandom)) % 2,
                    $urandom_range(0, 65535) - 32768,
                    $urandom_range(1, 30000),
                    $urandom_range(0, 4));
            repeat (40) begin
                @(negedge clk);
                en = ($urandom_range(0, 3) != 0);
            end
        end

        en = 1'b1;
        do_load(3000, 1234, 999, 1);
        repeat (7) @(negedge clk);
        #2 sclr_n = 1'b0;
        #1;
        chk("async_nd", int'(nd), 0);
        chk("async_ph", int'(phase_in), 0);
        chk("async_x", int'(x_in), 0);
        @(negedge clk);
        sclr_n = 1'b1;
        repeat (2) begin
            wait_nd(n);
            chk("post_rst_gap", n, 2);
            chk("post_rst_ph", int'(phase_in), 0);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cordic_phase_gen.md
# cordic_phase_gen

- Upstream phase/sample generator for the pipelined CORDIC rotation stage. It drives that stage's `nd`, `x_in`, `y_in` and `phase_in`.
- It keeps a signed phase accumulator in radians, Q2.13 (±π = ±25736), folds the accumulator back into [−π, +π] on every step, and adds a phase offset.
- It emits one `nd` strobe every programmable number of cycles, so the downstream stage works as an NCO / vector rotator.

## Interface
- `DATA_WIDTH`, 16: width of the phase and amplitude words.
- `PI_Q13`, 25736: π·2^13, rounded.
- `DIV_WIDTH`, 16: width of the sample-rate divider.
- `clk`  in  1: clock.
- `sclr_n`  in  1: reset, asynchronous, active-low.
- `en`  in  1: run enable. Tick counter advances only while high.
- `load`  in  1: one-cycle pulse. Latches the configuration and clears the accumulator and tick counter.
- `freq_word`  in  16 signed: phase increment per sample, Q2.13 radians.
- `phase_offset`  in  16 signed: constant phase added to the output, Q2.13.
- `amplitude`  in  16 signed: value driven on `x_in`.
- `rate_div`  in  DIV_WIDTH unsigned: tick period is `rate_div`+1 cycles.
- `nd`  out  1: single-cycle new-data strobe to the CORDIC.
- `x_in`  out  16 signed: `amplitude` as latched at the last `load`.
- `y_in`  out  16 signed: constant 0.
- `phase_in`  out  16 signed: output phase, always in [−PI_Q13, +PI_Q13].

## Operation
- **Config latch (`load`=1):**
  - Capture `freq_word` and `phase_offset` into shadow registers, each clamped to ±PI_Q13.
  - Capture `amplitude` and `rate_div` into shadow registers.
  - Clear `acc` and `cnt` to 0.
  - `load` has priority over a tick in the same cycle. `nd` is 0 on the following cycle.
- **Effective divider:** `div_eff` = max(shadow `rate_div`, 1).
  - The downstream stage samples `x_in`/`y_in`/`phase_in` in both the `nd` cycle and the cycle after it, so the outputs must never change on consecutive cycles.
- **Tick counter:** `tick` = `en` && (`cnt` == `div_eff`).
  - While `en` is high, `cnt` increments and wraps to 0 on `tick`.
  - While `en` is low, `cnt`, `acc` and all outputs hold, and `nd` stays 0.
- **On tick:**
  - `phase_in` ← wrap(`acc` + `offset_r`).
  - `acc` ← wrap(`acc` + `fw_r`).
  - `x_in` ← `amplitude_r`, `y_in` ← 0, `nd` ← 1.
  - The first sample after `load` is therefore `offset_r` alone.
- **Otherwise:** `nd` ← 0, and `phase_in`/`x_in`/`y_in` hold.
- **wrap(s):** computed in 18-bit signed arithmetic.
  - s > PI_Q13 → s − 2·PI_Q13.
  - s < −PI_Q13 → s + 2·PI_Q13.
  - else s.
  - Operands are within ±π, so one fold always suffices. The result is truncated to 16 bits with no loss.
- **Reset:** `acc`, `cnt`, all shadow registers, `nd`, `x_in`, `y_in` and `phase_in` all clear to 0 immediately on `sclr_n` low, even mid-stream.
  - After release, `div_eff` = 1, and `nd` pulses every 2 cycles while `en` is high, with phase 0 and amplitude 0.

## Timing
- Tick evaluated in cycle T → `nd` and new `phase_in` are visible from the edge ending T.
- Outputs are stable for at least `div_eff`+1 cycles.
- After the `load` edge with `en` held high, the first `nd` rises `div_eff`+1 edges later.
- `nd` is never high on two consecutive cycles.
- Configuration inputs are don't-care except in the `load` cycle.

## Structure
- Shared package `cordic_pkg` holds:
  - `DATA_WIDTH`.
  - `PI_Q13` (25736), `TWO_PI_Q13` (51472), `HALF_PI_Q13` (12868).
  - The Q2.13 arctan table, shared with the rotation stage.
- Sub-module `phase_wrap`: combinational 18-bit fold into [−π, π]. Instantiated twice, once for the accumulator and once for the offset add.
- Remaining RTL: shadow registers, clamp logic, tick counter, output registers.

## Test plan
- **Reset:** assert `sclr_n`=0 mid-stream → all outputs 0 asynchronously. After release with `en`=1 → `nd` every 2 cycles with `phase_in`=0.
- **Basic:** `load` with `fw`=1000, `offset`=0, `amp`=4096, `div`=3, `en`=1 → `nd` every 4 cycles; `phase_in` 0, 1000, 2000, 3000; `x_in`=4096, `y_in`=0.
- **Positive wrap:** `fw`=12868, `offset`=0 → `phase_in` 0, 12868, 25736, −12868, 0.
- **Negative wrap with offset:** `fw`=−20000, `offset`=−10000 → `phase_in` −10000, 21472, 1472.
- **Divider floor and clamp:** `div`=0 → `nd` period 2, never on back-to-back cycles. `fw`=30000 → behaves as 25736.
- **Control:** drop `en` for 5 cycles → no `nd`, outputs hold, then the sequence resumes. `load` coincident with a tick → no `nd` the next cycle, and the accumulator restarts from 0.
